e_x_postprocess: RTL and testbench
==================================

# e_x_postprocess

Rejection-sampling post-processor for the random-normal generator pipeline. Each cycle it takes a candidate sample (`origNum`), its exponent argument (`arg`) and an independent uniform random word (`testNum`). It computes the acceptance threshold e^(-arg) with a LUT and piecewise-linear approximation. The candidate is latched onto `number` only if `testNum` falls below that threshold; otherwise `number` keeps the last accepted sample.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arg` in 32: unsigned Q8.24 exponent x; 0x01000000 = 1.0.
- `origNum` in 32: candidate sample, opaque data, passed through unchanged.
- `testNum` in 32: uniform random, unsigned Q0.32 in [0,1).
- `number` out 32: last accepted candidate.

## Operation
- Split `arg`:
  - n = `arg[31:24]` (integer part).
  - k = `arg[23:20]` (segment index).
  - r = `arg[19:0]` (segment remainder).
- Fraction table, 17 entries, 25-bit unsigned: T[j] = round(2^24·e^(-j/16)), j = 0..16. T[0] = 0x1000000.
- Fraction term: y = T[k] − (((T[k] − T[k+1]) · r) >> 20).
  - y is 25-bit and lies in [T[k+1], T[k]].
  - r = 0 gives y = T[k] exactly.
- Integer table, 25-bit unsigned: E[m] = round(2^24·e^(-m)), m = 0..16. E[0] = 0x1000000.
- Integer term:
  - n ≤ 16: E[n].
  - n ≥ 17: 0, so the threshold is 0 and the candidate is always rejected.
- Threshold: th = (E[n] · y) >> 24, truncating, 25-bit, range [0, 2^24]. arg = 0 gives th = 2^24 exactly.
- Acceptance test is an unsigned 33-bit compare: accept iff {1'b0, testNum} < {th, 8'h00}.
  - th = 2^24 accepts every testNum.
  - th = 0 rejects every testNum.
- On accept, `number` ← the `origNum` that entered with the same `arg`/`testNum`. On reject, `number` holds.
- No handshake: a new sample is consumed every cycle while `rst` is low.
- Inputs are not required to be stable across cycles.

## Timing
- Three register stages:
  - S1, edge t: registers y, n (or an n≥17 flag), origNum, testNum, valid.
  - S2, edge t+1: registers th, origNum, testNum, valid.
  - S3, edge t+2: conditional update of `number`.
- Latency: inputs present before edge t affect `number` after edge t+2. Throughput is 1 per cycle.
- Internal valid bit:
  - Cleared by reset.
  - S1 valid is set on every non-reset edge.
  - S3 updates only when S2 valid = 1, so no garbage is accepted in the first cycles after reset.
- Reset value: `number` = 0x00000000. All pipeline data and valid registers = 0.
- Reset mid-operation: on the reset edge, in-flight samples are discarded and `number` clears. Samples entering after reset deasserts follow normal latency.
- Consecutive accepts update `number` every cycle. Consecutive rejects hold it indefinitely.

## Configuration
- `E_X_INTERP_EN` defined: linear interpolation as above, 17-entry T table.
- `E_X_INTERP_EN` not defined:
  - Step approximation y = T[k]. No interpolation multiplier.
  - Still uses the T[0..15] entries.
  - Latency and all other behaviour unchanged.
- The test plan values hold in both builds.

## Test plan
- Reset held 2 cycles with arg=0x01234567, origNum=0x10000000, testNum=0x02000000 → `number`=0 throughout reset. After release, `number`=0x10000000 exactly 3 edges later (th ≈ 0.32·2^24 > 0x020000 scaled).
- Same arg/origNum, testNum changed to 0x00000000 → accept; `number` stays 0x10000000. Then origNum=0x0000BEEF → `number`=0x0000BEEF 3 edges later.
- arg=0x00000000, testNum=0xFFFFFFFF, origNum=0x12345678 → accept (th=2^24); `number`=0x12345678.
- arg=0x11000000 (n=17), testNum=0x00000000, origNum=0xDEADBEEF → reject; `number` holds its previous value.
- arg=0x01000000, testNum=0xFFFFFFFF, origNum alternating 0xAAAA0000/0x5555FFFF → every sample rejected; `number` constant.
- Assert rst for 1 cycle mid-stream with accepting inputs → `number`=0 on that edge. The first post-reset accept appears 3 edges after release, with no earlier update.

Source files
------------

// File: rtl/e_x_postprocess.sv
// Rejection-sampling post-processor: accepts origNum when testNum < e^(-arg), 3-stage pipeline.
// Build option: define E_X_INTERP_EN for linear interpolation of the fraction table (default: step).
module e_x_postprocess (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] arg,
    input  logic [31:0] origNum,
    input  logic [31:0] testNum,
    output logic [31:0] number
);

    // round(2^24 * e^(-j/16))
    function automatic logic [24:0] t_lut(input logic [4:0] j);
        logic [24:0] v;
        case (j)
            5'd0:    v = 25'h1000000;
            5'd1:    v = 25'h0F07D60;
            5'd2:    v = 25'h0E1EB51;
            5'd3:    v = 25'h0D43B41;
            5'd4:    v = 25'h0C75F7D;
            5'd5:    v = 25'h0BB4B29;
            5'd6:    v = 25'h0AFF231;
            5'd7:    v = 25'h0A54939;
            5'd8:    v = 25'h09B4598;
            5'd9:    v = 25'h091DD4A;
            5'd10:   v = 25'h08906E5;
            5'd11:   v = 25'h080B992;
            5'd12:   v = 25'h078ED04;
            5'd13:   v = 25'h071996C;
            5'd14:   v = 25'h06AB778;
            5'd15:   v = 25'h0644044;
            5'd16:   v = 25'h05E2D59;
            default: v = 25'h0;
        endcase
        return v;
    endfunction

    // round(2^24 * e^(-m))
    function automatic logic [24:0] e_lut(input logic [4:0] m);
        logic [24:0] v;
        case (m)
            5'd0:    v = 25'h1000000;
            5'd1:    v = 25'h05E2D59;
            5'd2:    v = 25'h022A555;
            5'd3:    v = 25'h00CBED8;
            5'd4:    v = 25'h004B055;
            5'd5:    v = 25'h001B994;
            5'd6:    v = 25'h000A273;
            5'd7:    v = 25'h0003BC3;
            5'd8:    v = 25'h00015FC;
            5'd9:    v = 25'h0000816;
            5'd10:   v = 25'h00002FA;
            5'd11:   v = 25'h0000118;
            5'd12:   v = 25'h0000067;
            5'd13:   v = 25'h0000026;
            5'd14:   v = 25'h000000E;
            5'd15:   v = 25'h0000005;
            5'd16:   v = 25'h0000002;
            default: v = 25'h0;
        endcase
        return v;
    endfunction

    logic [24:0] y_d, y_q;
    logic [4:0]  n_d, n_q;
    logic        n_big_d, n_big_q;
    logic [31:0] orig1_d, orig1_q, test1_d, test1_q;
    logic        v1_d, v1_q;
    logic [24:0] th_d, th_q;
    logic [31:0] orig2_d, orig2_q, test2_d, test2_q;
    logic        v2_d, v2_q;
    logic [31:0] number_d, number_q;
    logic [24:0] e_val;
    logic [49:0] prod_th;
    logic        accept;

`ifdef E_X_INTERP_EN
    logic [24:0] t_hi, t_lo, t_diff;
    logic [40:0] prod_r;

    always_comb begin
        t_hi   = t_lut({1'b0, arg[23:20]});
        t_lo   = t_lut({1'b0, arg[23:20]} + 5'd1);
        t_diff = t_hi - t_lo;
        prod_r = 41'(t_diff) * 41'(arg[19:0]);
        y_d    = t_hi - 25'(prod_r >> 20);
    end
`else
    // The segment remainder only feeds the interpolator.
    logic unused_r;
    assign unused_r = ^arg[19:0];

    always_comb begin
        y_d = t_lut({1'b0, arg[23:20]});
    end
`endif

    always_comb begin
        n_big_d = (arg[31:24] > 8'd16);
        n_d     = arg[28:24];
        orig1_d = origNum;
        test1_d = testNum;
        v1_d    = 1'b1;

        // n >= 17 forces the threshold to zero so every candidate is rejected.
        e_val   = n_big_q ? 25'h0 : e_lut(n_q);
        prod_th = 50'(e_val) * 50'(y_q);
        th_d    = 25'(prod_th >> 24);
        orig2_d = orig1_q;
        test2_d = test1_q;
        v2_d    = v1_q;

        accept   = v2_q && ({1'b0, test2_q} < {th_q, 8'h00});
        number_d = accept ? orig2_q : number_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            n_q      <= '0;
            n_big_q  <= 1'b0;
            orig1_q  <= '0;
            test1_q  <= '0;
            v1_q     <= 1'b0;
            th_q     <= '0;
            orig2_q  <= '0;
            test2_q  <= '0;
            v2_q     <= 1'b0;
            number_q <= '0;
        end else begin
            y_q      <= y_d;
            n_q      <= n_d;
            n_big_q  <= n_big_d;
            orig1_q  <= orig1_d;
            test1_q  <= test1_d;
            v1_q     <= v1_d;
            th_q     <= th_d;
            orig2_q  <= orig2_d;
            test2_q  <= test2_d;
            v2_q     <= v2_d;
            number_q <= number_d;
        end
    end

    assign number = number_q;

endmodule

// File: tb/tb_e_x_postprocess.sv
// Directed self-checking bench for e_x_postprocess.
module tb_e_x_postprocess;

    logic        clk;
    logic        rst;
    logic [31:0] arg;
    logic [31:0] orig_num;
    logic [31:0] test_num;
    logic [31:0] number;

    int n_cmp;
    int n_bad;

    e_x_postprocess dut (
        .clk     (clk),
        .rst     (rst),
        .arg     (arg),
        .origNum (orig_num),
        .testNum (test_num),
        .number  (number)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive(input logic [31:0] a, input logic [31:0] o, input logic [31:0] t);
        arg      = a;
        orig_num = o;
        test_num = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h01234567, 32'h10000000, 32'h02000000);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (number !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, number, 32'h0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== ((i == 2) ? 32'h10000000 : 32'h0)) begin
                n_bad++;
                $display("FAIL reset_release_edge%0d: got %h expected %h", i + 1, number,
                         (i == 2) ? 32'h10000000 : 32'h0);
            end
        end
    endtask

    task automatic test_accept_zero();
        drive(32'h01234567, 32'h10000000, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== 32'h10000000) begin
                n_bad++;
                $display("FAIL testnum_zero[%0d]: got %h expected %h", i, number, 32'h10000000);
            end
        end
        drive(32'h01234567, 32'h0000BEEF, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== ((i == 2) ? 32'h0000BEEF : 32'h10000000)) begin
                n_bad++;
                $display("FAIL new_orig_edge%0d: got %h expected %h", i + 1, number,
                         (i == 2) ? 32'h0000BEEF : 32'h10000000);
            end
        end
    endtask

    task automatic test_th_max();
        drive(32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== ((i == 2) ? 32'h12345678 : 32'h0000BEEF)) begin
                n_bad++;
                $display("FAIL th_max_edge%0d: got %h expected %h", i + 1, number,
                         (i == 2) ? 32'h12345678 : 32'h0000BEEF);
            end
        end
    endtask

    task automatic test_n_overflow();
        drive(32'h11000000, 32'hDEADBEEF, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== 32'h12345678) begin
                n_bad++;
                $display("FAIL n17_reject[%0d]: got %h expected %h", i, number, 32'h12345678);
            end
        end
        drive(32'hFF000000, 32'hDEAD0001, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== 32'h12345678) begin
                n_bad++;
                $display("FAIL n255_reject[%0d]: got %h expected %h", i, number, 32'h12345678);
            end
        end
    endtask

    task automatic test_reject_stream();
        for (int i = 0; i < 6; i++) begin
            drive(32'h01000000, (i % 2 == 0) ? 32'hAAAA0000 : 32'h5555FFFF, 32'hFFFFFFFF);
            tick();
            n_cmp++;
            if (number !== 32'h12345678) begin
                n_bad++;
                $display("FAIL reject_stream[%0d]: got %h expected %h", i, number, 32'h12345678);
            end
        end
    endtask

    // Back-to-back samples straddling exact thresholds:
    // arg=1.0 -> th=0x5E2D59, arg=0.5 -> th=0x9B4598, arg=0 -> th=2^24.
    task automatic test_back_to_back();
        logic [31:0] v_arg [6];
        logic [31:0] v_orig[6];
        logic [31:0] v_test[6];
        logic        v_acc [6];
        logic [31:0] exp_num;
        v_arg[0] = 32'h01000000; v_orig[0] = 32'hA0000001; v_test[0] = 32'h5E2D58FF; v_acc[0] = 1'b1;
        v_arg[1] = 32'h01000000; v_orig[1] = 32'hA0000002; v_test[1] = 32'h5E2D5900; v_acc[1] = 1'b0;
        v_arg[2] = 32'h00800000; v_orig[2] = 32'hA0000003; v_test[2] = 32'h9B4597FF; v_acc[2] = 1'b1;
        v_arg[3] = 32'h00800000; v_orig[3] = 32'hA0000004; v_test[3] = 32'h9B459800; v_acc[3] = 1'b0;
        v_arg[4] = 32'h00000000; v_orig[4] = 32'hA0000005; v_test[4] = 32'hFFFFFFFF; v_acc[4] = 1'b1;
        v_arg[5] = 32'h00000000; v_orig[5] = 32'hA0000006; v_test[5] = 32'h00000000; v_acc[5] = 1'b1;
        exp_num = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(v_arg[i], v_orig[i], v_test[i]);
            else       drive(32'h11000000, 32'hBAD00000, 32'h00000000);
            tick();
            if (i >= 2 && v_acc[i-2]) exp_num = v_orig[i-2];
            n_cmp++;
            if (number !== exp_num) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, number, exp_num);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(32'h00000000, 32'hCAFE0001, 32'h00000000);
        tick(); tick(); tick();
        n_cmp++;
        if (number !== 32'hCAFE0001) begin
            n_bad++;
            $display("FAIL pre_reset_accept: got %h expected %h", number, 32'hCAFE0001);
        end
        rst = 1'b1;
        drive(32'h00000000, 32'hCAFE0002, 32'h00000000);
        tick();
        n_cmp++;
        if (number !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset_edge: got %h expected %h", number, 32'h0);
        end
        rst = 1'b0;
        drive(32'h00000000, 32'h0C0FFEE0, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (number !== ((i == 2) ? 32'h0C0FFEE0 : 32'h0)) begin
                n_bad++;
                $display("FAIL post_reset_edge%0d: got %h expected %h", i + 1, number,
                         (i == 2) ? 32'h0C0FFEE0 : 32'h0);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(32'h0, 32'h0, 32'h0);
        test_reset();
        test_accept_zero();
        test_th_max();
        test_n_overflow();
        test_reject_stream();
        test_back_to_back();
        test_mid_reset();
        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
